// File: rtl/qcl_burst_addr_gen_pkg.sv
// Shared types and default widths for the burst address generator.
package qcl_burst_pkg;

  localparam int LEN_WIDTH  = 8;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/qcl_burst_addr_gen_counter.sv
// Beat index counter that wraps to zero on the enabled cycle where count+1 reaches a runtime limit.
module qcl_counter_dynamic_limit_en
  import qcl_burst_pkg::*;
#(
  parameter int width_p = LEN_WIDTH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] limit_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o
);

  logic [width_p:0] count_inc;

  // One extra bit keeps count+1 from aliasing to zero at the maximum limit.
  assign count_inc  = {1'b0, count_o} + {{width_p{1'b0}}, 1'b1};
  assign overflow_o = (count_inc == {1'b0, limit_i});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= overflow_o ? '0 : count_inc[width_p-1:0];
    end
  end

endmodule

// File: rtl/qcl_burst_addr_gen.sv
// Turns a (base, length) burst command into a stream of per-beat addresses with valid/ready.
// Define QCL_BURST_ADDR_GEN_PIPELINE_EN to accept the next command on the final-beat handshake.
module qcl_burst_addr_gen
  import qcl_burst_pkg::*;
#(
  parameter int len_width_p  = LEN_WIDTH,
  parameter int addr_width_p = ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [addr_width_p-1:0] base_addr_i,
  input  logic [len_width_p-1:0]  len_i,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [addr_width_p-1:0] addr_o,
  output logic [len_width_p-1:0]  idx_o,
  output logic                    last_o,
  output logic                    busy_o
);

  state_e                  state_r, state_n;
  logic [addr_width_p-1:0] base_r;
  logic [len_width_p-1:0]  len_r;
  logic [len_width_p-1:0]  count;
  logic                    overflow;
  logic                    in_burst;
  logic                    beat_hs;
  logic                    load;

  // Outputs are forced quiet while reset is held, before the state register clears.
  assign in_burst = (state_r == BURST) && !reset_i;
  assign v_o      = in_burst;
  assign busy_o   = in_burst;
  assign last_o   = in_burst && overflow;
  assign idx_o    = reset_i ? '0 : count;
  assign addr_o   = reset_i ? '0 : base_r + addr_width_p'(count);
  assign beat_hs  = v_o && ready_i;

`ifdef QCL_BURST_ADDR_GEN_PIPELINE_EN
  assign ready_o = !reset_i && ((state_r == IDLE) || (last_o && ready_i));
`else
  assign ready_o = !reset_i && (state_r == IDLE);
`endif

  assign load = v_i && ready_o && (len_i != '0);

  qcl_counter_dynamic_limit_en #(
    .width_p (len_width_p)
  ) beat_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .limit_i    (len_r),
    .en_i       (beat_hs),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (load) state_n = BURST;
      end
      BURST: begin
        // A zero-length command taken on the last beat is dropped and the FSM idles.
        if (beat_hs && last_o) state_n = load ? BURST : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      base_r  <= '0;
      len_r   <= '0;
    end else begin
      state_r <= state_n;
      if (load) begin
        base_r <= base_addr_i;
        len_r  <= len_i;
      end
    end
  end

endmodule

// File: tb/tb_qcl_burst_addr_gen.sv
// Self-checking bench: queue-of-expected-beats reference model, directed scenarios plus random traffic.
module tb_qcl_burst_addr_gen;
  import qcl_burst_pkg::*;

  localparam int LW = 8;
  localparam int AW = 32;
`ifdef QCL_BURST_ADDR_GEN_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          ready_o;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          v_o;
  logic          ready_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic [LW-1:0] idx_o;
  logic          last_o;
  logic          busy_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
  } cmd_s;

  beat_t exp_q[$];
  cmd_s  cmd_q[$];
  bit    rdy_pat[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    hs_count = 0;
  bit    rand_ready = 1'b0;
  bit    rand_valid = 1'b0;

  qcl_burst_addr_gen #(
    .len_width_p  (LW),
    .addr_width_p (AW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .v_o         (v_o),
    .ready_i     (ready_i),
    .addr_o      (addr_o),
    .idx_o       (idx_o),
    .last_o      (last_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are checked mid-cycle, then the model advances for the coming edge.
  task automatic applyStimulus(input bit v, input logic [AW-1:0] base, input logic [LW-1:0] len,
                               input bit rdy, output bit accepted);
    bit    busy, exp_ready;
    beat_t f;
    @(negedge clk_i);
    reset_i = 1'b0;
    v_i = v;
    base_addr_i = base;
    len_i = len;
    ready_i = rdy;
    #1;
    busy = (exp_q.size() != 0);
    exp_ready = !busy || (PIPE && exp_q[0].last && rdy);
    checkOutput("v_o", {63'd0, v_o}, {63'd0, busy});
    checkOutput("busy_o", {63'd0, busy_o}, {63'd0, busy});
    checkOutput("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
    if (busy) begin
      f = exp_q[0];
      checkOutput("addr_o", {32'd0, addr_o}, {32'd0, f.addr});
      checkOutput("idx_o", {56'd0, idx_o}, {56'd0, f.idx});
      checkOutput("last_o", {63'd0, last_o}, {63'd0, f.last});
    end else begin
      checkOutput("last_o_idle", {63'd0, last_o}, 64'd0);
    end
    if (busy && rdy) begin
      void'(exp_q.pop_front());
      hs_count++;
    end
    accepted = v && exp_ready;
    if (accepted && len != 0) begin
      for (int i = 0; i < int'(len); i++) begin
        beat_t b;
        b.addr = base + AW'(i);
        b.idx  = LW'(i);
        b.last = (i == int'(len) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      reset_i = 1'b1;
      v_i = 1'b1;
      base_addr_i = $urandom;
      len_i = LW'($urandom_range(1, 9));
      ready_i = 1'b1;
      #1;
      checkOutput("rst_ready_o", {63'd0, ready_o}, 64'd0);
      checkOutput("rst_v_o", {63'd0, v_o}, 64'd0);
      checkOutput("rst_busy_o", {63'd0, busy_o}, 64'd0);
      checkOutput("rst_last_o", {63'd0, last_o}, 64'd0);
      checkOutput("rst_idx_o", {56'd0, idx_o}, 64'd0);
      checkOutput("rst_addr_o", {32'd0, addr_o}, 64'd0);
    end
    exp_q.delete();
    cmd_q.delete();
  endtask

  // Drives queued commands (held until accepted) and drains all expected beats within a budget.
  task automatic runCmds(input int budget);
    int            cyc;
    bit            v, r, acc;
    logic [AW-1:0] b;
    logic [LW-1:0] l;
    cyc = 0;
    while ((cmd_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      v = (cmd_q.size() != 0) && (!rand_valid || ($urandom_range(0, 1) == 1));
      b = v ? cmd_q[0].base : AW'($urandom);
      l = v ? cmd_q[0].len : LW'($urandom);
      if (rdy_pat.size() != 0) r = rdy_pat.pop_front();
      else r = rand_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(v, b, l, r, acc);
      if (acc) void'(cmd_q.pop_front());
      cyc++;
    end
    checkOutput("drain_in_budget", {63'd0, (cmd_q.size() == 0 && exp_q.size() == 0)}, 64'd1);
  endtask

  task automatic pushCmd(input logic [AW-1:0] base, input logic [LW-1:0] len);
    cmd_s c;
    c.base = base;
    c.len = len;
    cmd_q.push_back(c);
  endtask

  initial begin
    bit acc;
    int start, cyc;
    $display("[TB] start, pipeline=%0d", PIPE);
    doReset(3);
    applyStimulus(1'b0, '0, '0, 1'b1, acc);

    pushCmd(32'h0000_1000, 8'd4);
    runCmds(50);

    // Stall pattern: accept cycle, then ready 1,0,0,1,1,0,1.
    pushCmd(32'h0000_2000, 8'd4);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    runCmds(50);

    pushCmd(32'h0000_0040, 8'd0);
    pushCmd(32'h0000_0020, 8'd1);
    runCmds(50);

    pushCmd(32'hFFFF_FFFE, 8'd3);
    runCmds(50);

    pushCmd(32'h0001_0000, 8'd255);
    runCmds(600);

    // Reset in the middle of a 20-beat burst.
    pushCmd(32'h0003_0000, 8'd20);
    start = hs_count;
    cyc = 0;
    while (hs_count - start < 10 && cyc < 200) begin
      applyStimulus(cmd_q.size() != 0, 32'h0003_0000, 8'd20, 1'b1, acc);
      if (acc) void'(cmd_q.pop_front());
      cyc++;
    end
    checkOutput("mid_burst_reached", {63'd0, (hs_count - start == 10)}, 64'd1);
    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, AW'($urandom), LW'($urandom), 1'b1, acc);

    pushCmd(32'h0000_5000, 8'd2);
    pushCmd(32'h0000_6000, 8'd3);
    runCmds(50);

    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pushCmd(AW'($urandom), LW'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9)));
    end
    runCmds(2000);
    rand_valid = 1'b0;
    for (int i = 0; i < 10; i++) pushCmd(AW'($urandom), LW'($urandom_range(0, 4)));
    runCmds(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
